// File: rtl/bus_memory_responder_if.sv
// bus_memory_responder_if: MemoryBus request (ms) and response (sm) channel bundle.
//   ms channel: msID, msAddress, msData, msWrite, msValid (master -> slave), msTaken (slave -> master)
//   sm channel: smID, smData, smValid (slave -> master), smTaken (master -> slave)
interface bus_memory_responder_if #(
   parameter int DATA_WIDTH      = 24,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int MASTER_ID_WIDTH = 8
);
   logic [MASTER_ID_WIDTH-1:0] msID;
   logic [ADDRESS_WIDTH-1:0]   msAddress;
   logic [DATA_WIDTH-1:0]      msData;
   logic                       msWrite;
   logic                       msValid;
   logic                       msTaken;
   logic [MASTER_ID_WIDTH-1:0] smID;
   logic [DATA_WIDTH-1:0]      smData;
   logic                       smValid;
   logic                       smTaken;

   modport master (
      output msID, msAddress, msData, msWrite, msValid, smTaken,
      input  msTaken, smID, smData, smValid
   );

   modport slave (
      input  msID, msAddress, msData, msWrite, msValid, smTaken,
      output msTaken, smID, smData, smValid
   );
endinterface

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: MemoryBus slave serving requests from an on-chip synchronous RAM.
//   clock      : sole clock, rising edge
//   reset      : asynchronous, active-low
//   flush      : synchronous; drops the read in the pipeline and all queued responses
//   bus        : ms/sm channels (slave modport)
//   readCount  : accepted reads, 0 unless BUS_MEMORY_RESPONDER_STATS_EN is defined
//   writeCount : accepted writes, 0 unless BUS_MEMORY_RESPONDER_STATS_EN is defined
module bus_memory_responder #(
   parameter int                       DATA_WIDTH      = 24,
   parameter int                       ADDRESS_WIDTH   = 32,
   parameter int                       MASTER_ID_WIDTH = 8,
   parameter int                       DEPTH_LOG2      = 12,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
   parameter int                       RESP_DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   bus_memory_responder_if.slave bus,
   output logic [31:0]           readCount,
   output logic [31:0]           writeCount
);
   localparam int            PW   = $clog2(RESP_DEPTH);
   localparam logic [PW:0]   FULL = (PW+1)'(RESP_DEPTH);

   logic [DATA_WIDTH-1:0]      mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0]      idx;
   logic                       hit, accept, wr_acc, rd_acc, push, pop;
   logic                       p_valid_q, p_valid_d;
   logic [MASTER_ID_WIDTH-1:0] p_id_q, p_id_d;
   logic [DATA_WIDTH-1:0]      p_data_q;
   logic [MASTER_ID_WIDTH-1:0] f_id [RESP_DEPTH];
   logic [DATA_WIDTH-1:0]      f_data [RESP_DEPTH];
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]                count_q, count_d;

   always_comb begin
      idx       = bus.msAddress[DEPTH_LOG2-1:0];
      hit       = bus.msAddress[ADDRESS_WIDTH-1:DEPTH_LOG2] == BASE_ADDRESS[ADDRESS_WIDTH-1:DEPTH_LOG2];
      // a read needs a guaranteed FIFO slot: the one in the pipeline stage counts as taken
      accept    = reset && bus.msValid && hit && !flush &&
                  (bus.msWrite || (count_q + (PW+1)'(p_valid_q)) < FULL);
      wr_acc    = accept && bus.msWrite;
      rd_acc    = accept && !bus.msWrite;
      push      = p_valid_q && !flush;
      pop       = count_q != '0 && bus.smTaken && !flush;
      p_valid_d = rd_acc;
      p_id_d    = rd_acc ? bus.msID : p_id_q;
      wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(push);
      rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);
      count_d   = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   assign bus.msTaken = accept;
   assign bus.smValid = count_q != '0;
   // head is masked to zero while empty so reset and flush present clean outputs
   assign bus.smID    = bus.smValid ? f_id[rd_ptr_q] : '0;
   assign bus.smData  = bus.smValid ? f_data[rd_ptr_q] : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_valid_q <= 1'b0;
         p_id_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         p_valid_q <= p_valid_d;
         p_id_q    <= p_id_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // RAM and FIFO storage carry no reset so they map onto memory macros
   always_ff @(posedge clock) begin
      if (wr_acc) mem[idx] <= bus.msData;
      if (rd_acc) p_data_q <= mem[idx];
      if (push) begin
         f_id[wr_ptr_q]   <= p_id_q;
         f_data[wr_ptr_q] <= p_data_q;
      end
   end

`ifdef BUS_MEMORY_RESPONDER_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q + 32'(rd_acc);
      wr_cnt_d = wr_cnt_q + 32'(wr_acc);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign readCount  = rd_cnt_q;
   assign writeCount = wr_cnt_q;
`else
   assign readCount  = '0;
   assign writeCount = '0;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clock)
      if (reset) assert (!(push && !pop && count_q == FULL)) else $error("response FIFO overflow");
`endif
endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: vector table plus response scoreboard for bus_memory_responder.
module tb_bus_memory_responder;
   localparam int DW = 24, AW = 32, IW = 8;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [IW-1:0] id;
      logic          tk;
   } vec_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] d;
   } rsp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] readCount, writeCount;

   vec_t          vt[$];
   rsp_t          sbq[$];
   logic [DW-1:0] model [int];
   int            vectors = 0, miscompares = 0, exp_rd = 0, exp_wr = 0;

   always #5 clock = ~clock;

   bus_memory_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MASTER_ID_WIDTH(IW)) bus ();

   bus_memory_responder dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus),
      .readCount  (readCount),
      .writeCount (writeCount)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic accepted(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] id);
      rsp_t r;
      if (w) begin
         model[int'(a[11:0])] = d;
         exp_wr++;
      end else begin
         r.id = id;
         r.d  = model[int'(a[11:0])];
         sbq.push_back(r);
         exp_rd++;
      end
   endtask

   task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] id, input logic tk);
      bus.msValid = 1'b1; bus.msWrite = w; bus.msAddress = a; bus.msData = d; bus.msID = id;
      @(negedge clock);
      check("msTaken", bus.msTaken, tk);
      if (tk && bus.msTaken) accepted(w, a, d, id);
      @(posedge clock); #1;
      bus.msValid = 1'b0;
   endtask

   task automatic req_wait(input logic [AW-1:0] a, input logic [IW-1:0] id);
      int n = 0;
      bus.msValid = 1'b1; bus.msWrite = 1'b0; bus.msAddress = a; bus.msID = id;
      @(negedge clock);
      while (!bus.msTaken && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("msTaken_after_stall", bus.msTaken, 1);
      if (bus.msTaken) accepted(1'b0, a, '0, id);
      @(posedge clock); #1;
      bus.msValid = 1'b0;
   endtask

   task automatic drain;
      int n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      check("drain_pending", sbq.size(), 0);
      @(posedge clock); #1;
   endtask

   always @(negedge clock) begin
      if (reset && bus.smValid && bus.smTaken) begin
         if (sbq.size() == 0) check("spurious_rsp", 1, 0);
         else begin
            rsp_t e;
            e = sbq.pop_front();
            check("smID", bus.smID, e.id);
            check("smData", bus.smData, e.d);
         end
      end
   end

   initial begin
      bus.msValid = 1'b0; bus.msWrite = 1'b0; bus.msAddress = '0; bus.msData = '0; bus.msID = '0;
      bus.smTaken = 1'b1;

      vt.push_back('{1'b1, 32'h10, 24'hABCDEF, 8'd0, 1'b1});
      vt.push_back('{1'b0, 32'h10, 24'h0, 8'd5, 1'b1});
      for (int i = 0; i < 6; i++) vt.push_back('{1'b1, AW'(i), DW'(100 + i), 8'd0, 1'b1});
      for (int i = 1; i < 4; i++) vt.push_back('{1'b0, AW'(i), 24'h0, IW'(i), 1'b1});
      vt.push_back('{1'b1, 32'h1000, 24'h111111, 8'd0, 1'b0});
      vt.push_back('{1'b0, 32'h1000, 24'h0, 8'd9, 1'b0});
      vt.push_back('{1'b1, 32'hFFFFF010, 24'h222222, 8'd0, 1'b0});
      vt.push_back('{1'b1, 32'hFFF, 24'h5A5A5A, 8'd0, 1'b1});
      vt.push_back('{1'b0, 32'hFFF, 24'h0, 8'd6, 1'b1});
      vt.push_back('{1'b1, 32'h20, 24'h000001, 8'd0, 1'b1});
      vt.push_back('{1'b0, 32'h20, 24'h0, 8'd7, 1'b1});
      vt.push_back('{1'b1, 32'h20, 24'hFFFFFF, 8'd0, 1'b1});
      vt.push_back('{1'b0, 32'h20, 24'h0, 8'd8, 1'b1});

      // reset state, with a hitting write offered while in reset
      bus.msValid = 1'b1; bus.msWrite = 1'b1; bus.msAddress = 32'h10; bus.msData = 24'h777777;
      #12;
      check("rst_msTaken", bus.msTaken, 0);
      check("rst_smValid", bus.smValid, 0);
      check("rst_smID", bus.smID, 0);
      check("rst_smData", bus.smData, 0);
      check("rst_readCount", readCount, 0);
      check("rst_writeCount", writeCount, 0);
      bus.msValid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;

      foreach (vt[i]) req(vt[i].w, vt[i].a, vt[i].d, vt[i].id, vt[i].tk);
      drain();

      // write then read on the next cycle: new data, response exactly two cycles later
      req(1'b1, 32'h10, 24'hABCDEF, 8'd0, 1'b1);
      req(1'b0, 32'h10, 24'h0, 8'd5, 1'b1);
      @(negedge clock);
      check("lat_cycle1_smValid", bus.smValid, 0);
      @(negedge clock);
      check("lat_cycle2_smValid", bus.smValid, 1);
      drain();

      // out-of-window requests held for 10 cycles
      bus.msValid = 1'b1; bus.msWrite = 1'b1; bus.msAddress = 32'h1000; bus.msData = 24'h123456;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("miss_msTaken", bus.msTaken, 0);
         check("miss_smValid", bus.smValid, 0);
      end
      @(posedge clock); #1;
      bus.msValid = 1'b0;
      req(1'b0, 32'h0, 24'h0, 8'd7, 1'b1);
      drain();

      // backpressure: four credits, then the stalled reads complete in order
      bus.smTaken = 1'b0;
      for (int i = 0; i < 4; i++) req(1'b0, AW'(i), 24'h0, IW'(10 + i), 1'b1);
      bus.msValid = 1'b1; bus.msWrite = 1'b0; bus.msAddress = 32'h4; bus.msID = 8'd14;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("full_msTaken", bus.msTaken, 0);
         check("full_smData_hold", bus.smData, 24'd100);
      end
      @(posedge clock); #1;
      bus.smTaken = 1'b1;
      req_wait(32'h4, 8'd14);
      req_wait(32'h5, 8'd15);
      drain();

      // streaming: three reads give three consecutive response cycles
      fork
         begin
            for (int i = 1; i < 4; i++) req(1'b0, AW'(i), 24'h0, IW'(20 + i), 1'b1);
         end
         begin
            repeat (2) @(negedge clock);
            for (int i = 0; i < 3; i++) begin
               @(negedge clock);
               check("stream_smValid", bus.smValid, 1);
            end
            @(negedge clock);
            check("stream_end_smValid", bus.smValid, 0);
         end
      join
      drain();

      // flush with responses queued and one still in the pipeline
      bus.smTaken = 1'b0;
      for (int i = 1; i < 4; i++) req(1'b0, AW'(i), 24'h0, IW'(30 + i), 1'b1);
      flush = 1'b1;
      bus.msValid = 1'b1; bus.msWrite = 1'b0; bus.msAddress = 32'h10; bus.msID = 8'd39;
      @(negedge clock);
      check("flush_msTaken", bus.msTaken, 0);
      @(posedge clock); #1;
      flush = 1'b0;
      bus.msValid = 1'b0;
      sbq.delete();
      @(negedge clock);
      check("flush_smValid", bus.smValid, 0);
      @(posedge clock); #1;
      bus.smTaken = 1'b1;
      req(1'b0, 32'h10, 24'h0, 8'd40, 1'b1);
      drain();

`ifdef BUS_MEMORY_RESPONDER_STATS_EN
      check("readCount", readCount, 32'(exp_rd));
      check("writeCount", writeCount, 32'(exp_wr));
`else
      check("readCount_off", readCount, 0);
      check("writeCount_off", writeCount, 0);
`endif

      // asynchronous reset with two responses queued
      bus.smTaken = 1'b0;
      req(1'b0, 32'h10, 24'h0, 8'd41, 1'b1);
      req(1'b0, 32'h1, 24'h0, 8'd42, 1'b1);
      repeat (3) @(negedge clock);
      check("pre_reset_smValid", bus.smValid, 1);
      #1 reset = 1'b0;
      #1;
      check("async_reset_smValid", bus.smValid, 0);
      check("async_reset_readCount", readCount, 0);
      check("async_reset_writeCount", writeCount, 0);
      sbq.delete();
      exp_rd = 0;
      exp_wr = 0;
      #1 reset = 1'b1;
      @(posedge clock); #1;
      bus.smTaken = 1'b1;
      req(1'b0, 32'h10, 24'h0, 8'd43, 1'b1);
      drain();
`ifdef BUS_MEMORY_RESPONDER_STATS_EN
      check("post_reset_readCount", readCount, 32'(exp_rd));
`else
      check("post_reset_readCount_off", readCount, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
